// File: rtl/harv_dmem_wb_bridge_if.sv
// Bus bundles for the HARV data-memory bridge: the core request/grant port
// and the single-master Wishbone classic data_mem bus.
interface harv_dmem_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  wren;
  logic [1:0]            ben;
  logic                  usgn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  err;
  logic [31:0]           rdata;

  modport master (
    output req, wren, ben, usgn, addr, wdata,
    input  gnt, err, rdata
  );

  modport slave (
    input  req, wren, ben, usgn, addr, wdata,
    output gnt, err, rdata
  );
endinterface

interface harv_wb_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ack;

  modport master (
    output cyc, stb, we, sel, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  cyc, stb, we, sel, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/harv_dmem_wb_bridge.sv
// Converts HARV dmem request/grant accesses into Wishbone classic cycles with
// lane steering, load extension, misalignment detection and ack timeout.
module harv_dmem_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  harv_dmem_if.slave dmem,
  harv_wb_if.master  wb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] ben, input logic [1:0] off);
    if (ben[1]) return off != 2'b00;
    if (ben[0]) return off[0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] ben, input logic [1:0] off);
    if (ben[1]) return 4'b1111;
    if (ben[0]) return 4'b0011 << off;
    return 4'b0001 << off;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] ben, input logic [31:0] wdata);
    if (ben[1]) return wdata;
    if (ben[0]) return {2{wdata[15:0]}};
    return {4{wdata[7:0]}};
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] ben, input logic usgn);
    logic [31:0]        lane;
    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;
    lane   = word >> {off, 3'b000};
    half_s = signed'(lane[15:0]);
    byte_s = signed'(lane[7:0]);
    if (ben[1]) return word;
    if (ben[0]) return usgn ? {16'h0000, lane[15:0]} : 32'(half_s);
    return usgn ? {24'h000000, lane[7:0]} : 32'(byte_s);
  endfunction

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  cyc_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            off_q;
  logic [1:0]            ben_q;
  logic                  usgn_q;
  logic                  gnt_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      cnt     <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      off_q   <= 2'b00;
      ben_q   <= 2'b00;
      usgn_q  <= 1'b0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem.req) begin
            if (is_misaligned(dmem.ben, dmem.addr[1:0])) begin
              // Rejected without touching the bus; a failed load reads as zero.
              state <= RESP;
              gnt_q <= 1'b1;
              err_q <= 1'b1;
              if (!dmem.wren) rdata_q <= 32'h0;
            end else begin
              state   <= BUS;
              cnt     <= '0;
              cyc_q   <= 1'b1;
              we_q    <= dmem.wren;
              sel_q   <= lane_sel(dmem.ben, dmem.addr[1:0]);
              addr_q  <= {dmem.addr[ADDR_WIDTH-1:2], 2'b00};
              wdata_q <= lane_data(dmem.ben, dmem.wdata);
              off_q   <= dmem.addr[1:0];
              ben_q   <= dmem.ben;
              usgn_q  <= dmem.usgn;
            end
          end
        end

        BUS: begin
          // An ack in the last counted cycle takes priority over the timeout.
          if (wb.ack) begin
            state <= RESP;
            cyc_q <= 1'b0;
            gnt_q <= 1'b1;
            err_q <= 1'b0;
            if (!we_q) rdata_q <= load_extend(wb.rdata, off_q, ben_q, usgn_q);
          end else if (cnt == CNT_LAST) begin
            state <= RESP;
            cyc_q <= 1'b0;
            gnt_q <= 1'b1;
            err_q <= 1'b1;
            if (!we_q) rdata_q <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
          cnt   <= '0;
          gnt_q <= 1'b0;
          err_q <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cyc_q <= 1'b0;
          gnt_q <= 1'b0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb.cyc     = cyc_q;
  assign wb.stb     = cyc_q;
  assign wb.we      = we_q;
  assign wb.sel     = sel_q;
  assign wb.addr    = addr_q;
  assign wb.wdata   = wdata_q;
  assign dmem.gnt   = gnt_q;
  assign dmem.err   = err_q;
  assign dmem.rdata = rdata_q;

endmodule

// File: tb/tb_harv_dmem_wb_bridge.sv
// Bench for harv_dmem_wb_bridge: directed vector table, reset-abort sequence and
// randomized accesses checked against a behavioural access model.
module tb_harv_dmem_wb_bridge;

  localparam int TO = 4;

  logic clk;
  logic rstn;

  harv_dmem_if #(.ADDR_WIDTH(32)) dm ();
  harv_wb_if   #(.ADDR_WIDTH(32)) wbi ();

  harv_dmem_wb_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ADDR_WIDTH(32)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .dmem  (dm),
    .wb    (wbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wren;
    logic [1:0]  ben;
    logic        usgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] sdata;
    logic [3:0]  e_sel;
    logic [31:0] e_wbd;
    logic [31:0] e_addr;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_cyc;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_rd;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] d, input int off, input int nb,
                                        input logic usgn);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = (d >> (8 * off)) & mask;
    if (!usgn && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one access starting just after a posedge; returns just after a posedge.
  task automatic apply(input vec_t v, input string tag, input logic drop_req);
    int lat;
    int ncyc;
    int stb_bad;
    logic [3:0]  sel_s;
    logic [31:0] addr_s, wbd_s, rd_s;
    logic        we_s, err_s;
    lat = -1; ncyc = 0; stb_bad = 0;
    sel_s = 4'h0; addr_s = 32'h0; wbd_s = 32'h0; rd_s = 32'h0; we_s = 1'b0; err_s = 1'b0;
    dm.req = 1'b1; dm.wren = v.wren; dm.ben = v.ben; dm.usgn = v.usgn;
    dm.addr = v.addr; dm.wdata = v.wdata;
    wbi.ack = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wbi.stb !== wbi.cyc) stb_bad++;
      if (dm.gnt === 1'b1) begin
        lat = k; err_s = dm.err; rd_s = dm.rdata;
        if (wbi.cyc !== 1'b0) stb_bad++;
        break;
      end
      if (wbi.cyc === 1'b1) begin
        ncyc++;
        sel_s = wbi.sel; addr_s = wbi.addr; wbd_s = wbi.wdata; we_s = wbi.we;
        wbi.ack = (ncyc - 1 == v.ack_at);
        wbi.rdata = wbi.ack ? v.sdata : $urandom;
        if (drop_req) dm.req = 1'b0;
      end else begin
        wbi.ack = 1'b0;
      end
      @(posedge clk); #1;
    end
    dm.req = 1'b0;
    wbi.ack = 1'b0;
    @(posedge clk); #1;
    check({tag, ".gnt_latency"}, 32'(lat), 32'(v.e_lat));
    check({tag, ".gnt_pulse"}, 32'(dm.gnt), 32'd0);
    check({tag, ".err"}, 32'(err_s), 32'(v.e_err));
    check({tag, ".rdata"}, rd_s, v.e_rd);
    check({tag, ".cyc_cycles"}, 32'(ncyc), 32'(v.e_cyc));
    check({tag, ".stb_eq_cyc"}, 32'(stb_bad), 32'd0);
    if (v.e_cyc > 0) begin
      check({tag, ".sel"}, 32'(sel_s), 32'(v.e_sel));
      check({tag, ".wb_addr"}, addr_s, v.e_addr);
      check({tag, ".wb_data"}, wbd_s, v.e_wbd);
      check({tag, ".we"}, 32'(we_s), 32'(v.wren));
    end
  endtask

  function automatic vec_t model(input logic wren, input logic [1:0] ben, input logic usgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int ack_at, input logic [31:0] sdata,
                                 input logic [31:0] prev);
    vec_t v;
    int nb;
    int off;
    logic mis;
    v.wren = wren; v.ben = ben; v.usgn = usgn; v.addr = addr; v.wdata = wdata;
    v.ack_at = ack_at; v.sdata = sdata;
    nb  = ben[1] ? 4 : (ben[0] ? 2 : 1);
    off = int'(addr % 4);
    mis = (addr % nb) != 0;
    v.e_sel = 4'h0; v.e_wbd = 32'h0; v.e_addr = 32'h0;
    if (mis) begin
      v.e_lat = 1; v.e_cyc = 0; v.e_err = 1'b1;
      v.e_rd = wren ? prev : 32'h0;
    end else begin
      v.e_sel  = 4'(((1 << nb) - 1) << off);
      v.e_addr = addr - 32'(off);
      v.e_wbd  = (nb == 4) ? wdata : (nb == 2) ? 32'(wdata[15:0]) * 32'h0001_0001
                                               : 32'(wdata[7:0]) * 32'h0101_0101;
      if (ack_at >= 0 && ack_at < TO) begin
        v.e_cyc = ack_at + 1; v.e_lat = ack_at + 2; v.e_err = 1'b0;
        v.e_rd  = wren ? prev : m_ext(sdata, off, nb, usgn);
      end else begin
        v.e_cyc = TO; v.e_lat = TO + 1; v.e_err = 1'b1;
        v.e_rd  = wren ? prev : 32'h0;
      end
    end
    return v;
  endfunction

  initial begin
    vec_t rv;
    logic [1:0] ben_r, off_r;
    rstn = 1'b0;
    dm.req = 1'b0; dm.wren = 1'b0; dm.ben = 2'b00; dm.usgn = 1'b0;
    dm.addr = 32'h0; dm.wdata = 32'h0;
    wbi.ack = 1'b0; wbi.rdata = 32'h0;

    vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0,        32'h100, 1'b0, 32'hDEADBEEF, 2, 1};
    vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        0, 32'h80FF1234, 4'h8, 32'h0,        32'h200, 1'b0, 32'hFFFFFF80, 2, 1};
    vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        0, 32'h80FF1234, 4'h8, 32'h0,        32'h200, 1'b0, 32'h00000080, 2, 1};
    vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h402, 32'h0000ABCD, 0, 32'h0,        4'hC, 32'hABCDABCD, 32'h400, 1'b0, 32'h00000080, 2, 1};
    vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h401, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,   1'b1, 32'h0,        1, 0};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h402, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,   1'b1, 32'h0,        1, 0};
    vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,       -1, 32'h0,        4'hF, 32'h0,        32'h010, 1'b1, 32'h0,        5, 4};
    vt[7]  = '{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        3, 32'h12345678, 4'hF, 32'h0,        32'h010, 1'b0, 32'h12345678, 5, 4};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h206, 32'h0,        1, 32'h80017FFF, 4'hC, 32'h0,        32'h204, 1'b0, 32'hFFFF8001, 3, 2};
    vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h301, 32'h000000A5, 2, 32'h0,        4'h2, 32'hA5A5A5A5, 32'h300, 1'b0, 32'hFFFF8001, 4, 3};
    vt[10] = '{1'b0, 2'b11, 1'b1, 32'h000, 32'h0,        0, 32'h80000000, 4'hF, 32'h0,        32'h000, 1'b0, 32'h80000000, 2, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset.cyc", 32'(wbi.cyc), 32'd0);
    check("reset.stb", 32'(wbi.stb), 32'd0);
    check("reset.gnt", 32'(dm.gnt), 32'd0);
    check("reset.err", 32'(dm.err), 32'd0);
    check("reset.rdata", dm.rdata, 32'h0);
    check("reset.sel", 32'(wbi.sel), 32'd0);
    check("reset.addr", wbi.addr, 32'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) apply(vt[i], $sformatf("vec%0d", i), 1'b0);

    // Reset in the middle of a bus cycle aborts it without a grant.
    dm.req = 1'b1; dm.wren = 1'b0; dm.ben = 2'b10; dm.usgn = 1'b0; dm.addr = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid.cyc_before", 32'(wbi.cyc), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rstmid.cyc", 32'(wbi.cyc), 32'd0);
    check("rstmid.stb", 32'(wbi.stb), 32'd0);
    check("rstmid.gnt", 32'(dm.gnt), 32'd0);
    dm.req = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    apply('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D, 4'hF, 32'h0, 32'h100,
            1'b0, 32'hCAFEF00D, 2, 1}, "rstmid.reload", 1'b0);
    prev_rd = 32'hCAFEF00D;

    for (int i = 0; i < 150; i++) begin
      ben_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) off_r = 2'($urandom_range(0, 3));
      else if (ben_r[1]) off_r = 2'b00;
      else if (ben_r[0]) off_r = {1'b0 + 1'($urandom_range(0, 1)), 1'b0};
      else off_r = 2'($urandom_range(0, 3));
      rv = model(1'($urandom_range(0, 1)), ben_r, 1'($urandom_range(0, 1)),
                 {$urandom, 2'b00} | {30'h0, off_r}, $urandom,
                 $urandom_range(0, 6) - 1, $urandom, prev_rd);
      apply(rv, $sformatf("rnd%0d", i), 1'($urandom_range(0, 1)));
      prev_rd = rv.e_rd;
      repeat ($urandom_range(0, 2)) begin
        wbi.ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      wbi.ack = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/harv_dmem_wb_bridge.md
Name: harv_dmem_wb_bridge

Overview:
Converts the HARV core's data-memory request/grant port into a single-master Wishbone classic cycle on the data_mem bus.
- Sits between the core's dmem_* outputs and the data_mem_* bus toward the Controller or testbench memory.
- Handles byte/halfword lane steering, write strobes, read sign/zero extension, misalignment errors and bus timeout.
- Replaces the current direct wiring, which drops ben/usgn and ties off error inputs.

Parameters:
TIMEOUT_CYCLES, 255, cycles of cyc without ack before aborting (1..65535; counter width $clog2(TIMEOUT_CYCLES+1)).
ADDR_WIDTH, 32, address width on both sides.

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
dmem_req_i  in  1  core request; held stable with all qualifiers until dmem_gnt_o
dmem_wren_i  in  1  1 = store, 0 = load
dmem_ben_i  in  2  size: 00 byte, 01 halfword, 1x word
dmem_usgn_i  in  1  load zero-extends when 1, sign-extends when 0
dmem_addr_i  in  ADDR_WIDTH  byte address
dmem_wdata_i  in  32  store data, right-justified
dmem_gnt_o  out  1  one-cycle completion pulse
dmem_err_o  out  1  valid with gnt: misaligned or timeout
dmem_rdata_o  out  32  extended load data, valid with gnt; holds until next gnt
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe (equals cyc)
wb_we_o  out  1  write enable
wb_sel_o  out  4  byte strobes
wb_addr_o  out  ADDR_WIDTH  word-aligned address, bits[1:0] = 0
wb_data_o  out  32  lane-steered write data
wb_data_i  in  32  read data
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, state IDLE, timeout counter 0. Assertion mid-cycle drops cyc/stb immediately; no gnt is issued for the aborted access.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On dmem_req_i, check alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
  - Misaligned: go to RESP with err=1 and no bus activity.
  - Aligned: register we, sel, word address and steered data; go to BUS with cyc=stb=1 on the next cycle.
- Lane steering, with o = addr[1:0]:
  - Byte: sel = 0001<<o; wb_data = {4{wdata[7:0]}}.
  - Halfword: sel = 0011<<o; wb_data = {2{wdata[15:0]}}.
  - Word: sel = 1111; wb_data = wdata.
  - sel is also driven on reads.
- BUS:
  - cyc/stb/we/sel/addr/data held stable.
  - On wb_ack_i: capture wb_data_i, extract the lane at offset o, extend per size/usgn (word ignores usgn), clear cyc/stb the next cycle, go to RESP with err=0.
  - Each cycle without ack increments the counter. When it reaches TIMEOUT_CYCLES-1 with no ack, drop cyc/stb and go to RESP with err=1, rdata=0.
  - An ack in the final counted cycle wins over timeout.
- RESP: gnt_o=1 and err_o valid for exactly one cycle, then IDLE; counter cleared.
- Timing:
  - Aligned access with zero-wait ack (ack in first BUS cycle): gnt 2 cycles after req is first seen.
  - A req still high in the cycle after gnt (next access) is accepted in that IDLE cycle; min 3 cycles per access.
- dmem_req_i dropping during BUS is ignored; the transaction completes and gnt still pulses.
- wb_ack_i outside BUS is ignored.
- dmem_rdata_o updates only in RESP; stores leave it unchanged.

Test Plan:
- Word load, addr 0x100, slave acks next cycle with 0xDEADBEEF -> sel=1111, wb_addr=0x100, gnt with rdata=0xDEADBEEF, err=0, gnt 2 cycles after req.
- Byte loads from addr 0x203, wb_data_i=0x80FF_1234 -> sel=1000; usgn=0 gives rdata=0xFFFFFF80; usgn=1 gives 0x00000080.
- Halfword store addr 0x402, wdata=0x0000ABCD -> sel=1100, wb_data=0xABCDABCD, we=1, wb_addr=0x400, gnt pulses once.
- Misaligned: halfword at 0x401 and word at 0x402 -> no cyc ever asserted, gnt+err=1 one cycle after req.
- Timeout with TIMEOUT_CYCLES=4, slave never acks -> cyc high exactly 4 cycles, then gnt+err=1, rdata=0. Repeat with ack in 4th cycle -> err=0.
- Reset asserted during BUS -> cyc/stb/gnt go 0 asynchronously; after release, a new word load completes normally.
